pipe_mem_arbiter: RTL
=====================

# pipe_mem_arbiter

Arbiter and sequencer that shares one single-port, fixed-latency unified memory between the pipelined CPU's instruction-fetch stage and its MEM-stage data port. It grants one access at a time, drives the memory for exactly LATENCY cycles, and returns registered read data with a one-cycle ready pulse. The pipeline uses `~ready` as its per-stage stall. It sits between `pipelinedcpu`'s IF/MEM stages and the memory model.

## Interface
- LATENCY, 2, memory access cycles per transfer (≥1)
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  system clock, rising edge
- clrn  in  1  reset; one clock, reset is asynchronous and active-low
- i_req  in  1  fetch request; held until i_ready
- i_addr  in  AW  fetch address; stable while i_req
- i_rdata  out  DW  registered fetch data
- i_ready  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_rdata  out  DW  registered load data
- d_ready  out  1  one-cycle data completion pulse
- m_en  out  1  memory access active
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data; valid in the last access cycle
- busy  out  1  high in ACCESS or RESP

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ACCESS: count LATENCY cycles.
  - RESP: one cycle; pulse ready.
- Transitions:
  - IDLE→ACCESS when any req is high.
  - ACCESS→RESP when cnt == LATENCY-1.
  - RESP→IDLE always.
- Grant (in IDLE):
  - Only one req high: that side wins.
  - Both high: data wins (fixed priority; the older instruction goes first).
- At grant, register m_addr and m_wdata from the winner. m_we = d_we for data, 0 for fetch. Set the grant register. Clear cnt.
- ACCESS: m_en = 1 and m_we, m_addr, m_wdata are held constant. cnt increments and saturates at LATENCY-1. Its width is $clog2(LATENCY+1).
- Last ACCESS cycle: capture m_rdata into i_rdata or d_rdata (per grant), for reads only. A data write leaves d_rdata unchanged.
- RESP: i_ready or d_ready = 1 for the granted side only. m_en = 0. Requests are ignored during this cycle.
- A requester dropping req mid-access is illegal. The access still completes and ready still pulses.
- Reset values (asynchronous, on clrn = 0): state IDLE, cnt 0, m_en/m_we/i_ready/d_ready/busy 0, m_addr/m_wdata/i_rdata/d_rdata 0, last-grant = fetch.
- Reset mid-access aborts immediately; no ready pulse. After release, requests still held are served from scratch.

## Timing
- Request visible in IDLE cycle t:
  - m_en high in cycles t+1 … t+LATENCY.
  - ready in cycle t+LATENCY+1.
  - Next arbitration in cycle t+LATENCY+2.
- Throughput: one access per LATENCY+2 cycles.
- Conflicting requests: the loser's ready arrives LATENCY+2 cycles after the winner's.
- All outputs are registered. No combinational path from a req input to any output.

## Configuration
- PIPE_MEM_ARB_RR_EN defined: round-robin on conflicts. A 1-bit last-grant register is updated on every grant, and on a conflict the side not granted last wins. Last-grant resets to fetch, so the first conflict goes to data.
- Undefined: fixed data-over-fetch priority. The last-grant register is not built.
- Uncontested behaviour is identical in both builds.

## Structure
- Package pipe_mem_pkg:
  - state_t enum {IDLE, ACCESS, RESP}.
  - grant_t enum {GNT_I, GNT_D}.
- Sub-module pipe_mem_wait_cnt: LATENCY-parameterised counter with clear, enable and done (cnt == LATENCY-1).

## Test plan
- LATENCY=2; fetch only, i_addr=0x0000_0040, memory returns 0x8C01_0000 → m_en in cycles 1–2; i_ready in cycle 3 with i_rdata=0x8C01_0000; d_ready stays 0.
- Simultaneous requests, fixed build: d write to 0x100 with 0xDEADBEEF, plus fetch → data first with m_we=1 and d_ready at cycle 3; fetch re-arbitrated at cycle 4 with i_ready at cycle 7; d_rdata unchanged.
- PIPE_MEM_ARB_RR_EN; both reqs held continuously for 4 accesses → grant order D, I, D, I; readies at cycles 3, 7, 11, 15.
- LATENCY=1; continuous fetch of consecutive addresses 0x0, 0x4, 0x8 → i_ready every 3 cycles; m_en one cycle per access.
- Data read with LATENCY=3 at 0x200, memory returns 0x1234_5678 → d_ready at cycle 4 with d_rdata=0x1234_5678; m_addr held at 0x200 for all 3 ACCESS cycles.
- clrn pulsed low during the 2nd ACCESS cycle → m_en, busy and ready drop asynchronously; no ready pulse; after release the held request completes LATENCY+1 cycles after its IDLE cycle.

Source files
------------

// File: rtl/pipe_mem_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter.
// Build option: PIPE_MEM_ARB_RR_EN selects round-robin conflict grant.
package pipe_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } grant_t;

endpackage

// File: rtl/pipe_mem_wait_cnt.sv
// Access-cycle counter: clear, enable, saturating at LATENCY-1.
// Ports: clk, clrn, clr_i, en_i in; done_o out (cnt == LATENCY-1).
module pipe_mem_wait_cnt #(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic clrn,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != LAST))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Shares one fixed-latency memory between IF fetch and MEM data port.
// Ports: clk/clrn; i_* fetch side; d_* data side; m_* memory; busy.
// Build option: PIPE_MEM_ARB_RR_EN (round-robin on conflicts).
module pipe_mem_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  state_t        state_q, state_d;
  grant_t        gnt_q, gnt_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] irdata_q, irdata_d;
  logic [DW-1:0] drdata_q, drdata_d;
  logic          irdy_q, irdy_d;
  logic          drdy_q, drdy_d;
  logic          busy_q, busy_d;
  logic          cnt_clr, cnt_en, cnt_done;
  logic          sel_d;

`ifdef PIPE_MEM_ARB_RR_EN
  grant_t last_q, last_d;
  // On a conflict, the side not served last time wins.
  assign sel_d = d_req & (~i_req | (last_q == GNT_I));
`else
  assign sel_d = d_req;
`endif

  pipe_mem_wait_cnt #(
    .LATENCY(LATENCY)
  ) u_cnt (
    .clk   (clk),
    .clrn  (clrn),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .done_o(cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    en_d     = en_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    irdy_d   = 1'b0;
    drdy_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
`ifdef PIPE_MEM_ARB_RR_EN
    last_d   = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = ACCESS;
          en_d    = 1'b1;
          cnt_clr = 1'b1;
          if (sel_d) begin
            gnt_d   = GNT_D;
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            gnt_d   = GNT_I;
            we_d    = 1'b0;
            addr_d  = i_addr;
            wdata_d = '0;
          end
`ifdef PIPE_MEM_ARB_RR_EN
          last_d = sel_d ? GNT_D : GNT_I;
`endif
        end
      end
      ACCESS: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          state_d = RESP;
          en_d    = 1'b0;
          we_d    = 1'b0;
          // m_rdata is valid in this last access cycle.
          if (gnt_q == GNT_I) begin
            irdata_d = m_rdata;
            irdy_d   = 1'b1;
          end else begin
            if (!we_q) drdata_d = m_rdata;
            drdy_d = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        we_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= IDLE;
      gnt_q    <= GNT_I;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      irdy_q   <= 1'b0;
      drdy_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      irdy_q   <= irdy_d;
      drdy_q   <= drdy_d;
      busy_q   <= busy_d;
    end
  end

`ifdef PIPE_MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) last_q <= GNT_I;
    else       last_q <= last_d;
  end
`endif

  assign m_en    = en_q;
  assign m_we    = we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_rdata = irdata_q;
  assign i_ready = irdy_q;
  assign d_rdata = drdata_q;
  assign d_ready = drdy_q;
  assign busy    = busy_q;

endmodule
